dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Data-bus responder (memory side) for the core's dbus_req_t / dbus_resp_t interface.
- Models a single-port, byte-strobed SRAM with a programmable access latency.
- Used as the data-memory endpoint in core-level simulation and as the slave-side reference for bus-bridge work.
- Handles one outstanding request at a time; it also flags out-of-range accesses and counts completed reads and writes.

Parameters:
- DEPTH, 4096, number of 64-bit words (power of two, >=2).
- BASE, 64'h8000_0000, byte address mapped to word 0.
- LATENCY, 2, cycles from request acceptance to response (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- dreq  input  dbus_req_t  fields: valid, addr[63:0], size[2:0], strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  fields: addr_ok, data_ok, data[63:0].
- err  output  1  pulses with data_ok when the completed access was out of range.
- rd_cnt  output  32  completed in-range reads; wraps at 2^32.
- wr_cnt  output  32  completed in-range writes; wraps at 2^32.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, all dresp fields 0, err=0, rd_cnt=wr_cnt=0, latency counter=0, latched request cleared.
  - Memory array contents are not cleared.
  - Reset asserted mid-access abandons the access; no memory write occurs.
- Request classes:
  - Write: dreq.strobe!=0. Read: dreq.strobe==0.
  - size is latched but does not alter behaviour: reads return the full aligned word, and writes use strobe only.
- Address map:
  - off=addr-BASE (64-bit subtraction); word index = off[3 +: log2(DEPTH)].
  - In range iff addr>=BASE and off < DEPTH*8. addr[2:0] is ignored for indexing.
- States:
  - IDLE: outputs 0. On a rising edge with dreq.valid==1, latch addr/strobe/data/size and compute in-range. Go to RESP if LATENCY==1; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: sample dreq.valid each edge. If 0, abort to IDLE (no write, no response, no counter update). If cnt==0, go to RESP; else cnt-=1.
  - RESP: lasts exactly one cycle. dresp.addr_ok=dresp.data_ok=1.
    - In-range read: dresp.data = mem[idx] as held before this cycle's edge.
    - Write, or any out-of-range access: dresp.data = 0.
    - err=1 iff out of range.
    - At the edge ending RESP: an in-range write merges byte lane i from data[8i+7:8i] where strobe[i]==1 (other lanes unchanged), and rd_cnt or wr_cnt increments (in-range only). Then go to IDLE.
- Latency: dreq.valid first seen high in IDLE during cycle 0 gives data_ok high in cycle LATENCY (combinational-free outputs, all registered).
- Back-to-back:
  - The initiator changes or drops dreq in the cycle after data_ok.
  - dreq.valid high in the cycle after RESP is accepted as a new request, even if unchanged, so there is zero bubble.
  - A read following a write to the same word returns the merged data.
- An out-of-range write never modifies memory; an out-of-range read returns 0.
- dreq changes during WAIT other than valid dropping are ignored (latched values are used).
- Counters wrap from 32'hFFFF_FFFF to 0 silently.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles with dreq.valid=1 → dresp all 0, err=0, rd_cnt=wr_cnt=0. After release, the first acceptance happens at the next edge.
- Full write then read, LATENCY=2:
  - Write addr 0x8000_0010, strobe 0xFF, data 0x1122334455667788 → data_ok high exactly 2 cycles after valid, for 1 cycle; wr_cnt=1.
  - Read of the same address → data 0x1122334455667788; rd_cnt=1.
- Partial strobe:
  - Prior word 0x1122334455667788; write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB.
  - Read back 0x11223344_BBBBBBBB.
- Out of range:
  - Read 0x7FFF_FFF8 → data_ok with data 0, err=1, rd_cnt unchanged.
  - Write BASE+DEPTH*8 with strobe 0xFF → err=1; word 0 unchanged.
- Abort: drop valid in the WAIT cycle of a write (LATENCY=3) → no data_ok, memory unchanged, wr_cnt unchanged. A new read issued next cycle completes 3 cycles later.
- Back-to-back with LATENCY=1: hold valid high across 4 reads of consecutive words → data_ok every other cycle (accept, respond) with the correct data each time, then rd_cnt=4. Asserting reset mid-sequence immediately clears dresp and the counters.

Source files
------------

// File: rtl/dbus_sram_responder_if.sv
// rtl/dbus_sram_responder_if.sv - dbus request/response bundle between an initiator and the SRAM responder
interface dbus_sram_responder_if;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - single-outstanding byte-strobed SRAM responder with programmable latency
module dbus_sram_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  dbus_sram_responder_if.slave        bus,
  output logic                        err,
  output logic [31:0]                 rd_cnt,
  output logic [31:0]                 wr_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          inr_q, inr_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic          dok_q, dok_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   rd_cnt_q, rd_cnt_d;
  logic [31:0]   wr_cnt_q, wr_cnt_d;

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   off;
  logic [63:0]   wmerge;
  logic [AW-1:0] req_idx;
  logic          req_inr;
  logic          mem_we;
  logic          unused_bits;

  assign off     = bus.dreq.addr - BASE;
  assign req_idx = off[3 +: AW];
  assign req_inr = (bus.dreq.addr >= BASE) && (off[63:AW+3] == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    inr_d    = inr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    dok_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.dreq.valid) begin
          idx_d    = req_idx;
          inr_d    = req_inr;
          strobe_d = bus.dreq.strobe;
          wdata_d  = bus.dreq.data;
          size_d   = bus.dreq.size;
          if (LATENCY == 1) begin
            state_d = RESP;
            dok_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (!bus.dreq.valid) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          dok_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (inr_q) begin
          if (strobe_q != '0) wr_cnt_d = wr_cnt_q + 32'd1;
          else                rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Read data is captured on the edge entering RESP; a write only lands on the edge leaving it.
    if (dok_d) begin
      err_d = !inr_d;
      if (inr_d && strobe_d == '0) rdata_d = mem_q[idx_d];
    end
  end

  always_comb begin
    wmerge = mem_q[idx_q];
    for (int i = 0; i < 8; i++) begin
      if (strobe_q[i]) wmerge[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  assign mem_we = (state_q == RESP) && inr_q && (strobe_q != '0);

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wmerge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      inr_q    <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      dok_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      inr_q    <= inr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      dok_q    <= dok_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.dresp.addr_ok = dok_q;
  assign bus.dresp.data_ok = dok_q;
  assign bus.dresp.data    = rdata_q;
  assign err               = err_q;
  assign rd_cnt            = rd_cnt_q;
  assign wr_cnt            = wr_cnt_q;

  // size only travels with the request; byte offset bits never select a word.
  assign unused_bits = ^{size_q, off[2:0]};
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - table and scoreboard bench for dbus_sram_responder at latencies 1, 2 and 3
module tb_dbus_sram_responder;
  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dbus_sram_responder_if bus1 ();
  dbus_sram_responder_if bus2 ();
  dbus_sram_responder_if bus3 ();
  logic        err1, err2, err3;
  logic [31:0] rd1, wr1, rd2, wr2, rd3, wr3;

  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .err(err1), .rd_cnt(rd1), .wr_cnt(wr1));
  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .bus(bus2), .err(err2), .rd_cnt(rd2), .wr_cnt(wr2));
  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .bus(bus3), .err(err3), .rd_cnt(rd3), .wr_cnt(wr3));

  int          sel = 2;
  logic        r_valid = 1'b0;
  logic [63:0] r_addr = '0;
  logic [63:0] r_data = '0;
  logic [2:0]  r_size = '0;
  logic [7:0]  r_strobe = '0;

  always_comb begin
    bus1.dreq.valid = r_valid && (sel == 1);
    bus1.dreq.addr = r_addr; bus1.dreq.size = r_size; bus1.dreq.strobe = r_strobe; bus1.dreq.data = r_data;
    bus2.dreq.valid = r_valid && (sel == 2);
    bus2.dreq.addr = r_addr; bus2.dreq.size = r_size; bus2.dreq.strobe = r_strobe; bus2.dreq.data = r_data;
    bus3.dreq.valid = r_valid && (sel == 3);
    bus3.dreq.addr = r_addr; bus3.dreq.size = r_size; bus3.dreq.strobe = r_strobe; bus3.dreq.data = r_data;
  end

  logic        obs_dok, obs_aok, obs_err;
  logic [63:0] obs_data;
  logic [31:0] obs_rd, obs_wr;
  always_comb begin
    obs_dok = 1'b0; obs_aok = 1'b0; obs_err = 1'b0; obs_data = '0; obs_rd = '0; obs_wr = '0;
    case (sel)
      1: begin obs_dok = bus1.dresp.data_ok; obs_aok = bus1.dresp.addr_ok; obs_data = bus1.dresp.data;
               obs_err = err1; obs_rd = rd1; obs_wr = wr1; end
      2: begin obs_dok = bus2.dresp.data_ok; obs_aok = bus2.dresp.addr_ok; obs_data = bus2.dresp.data;
               obs_err = err2; obs_rd = rd2; obs_wr = wr2; end
      3: begin obs_dok = bus3.dresp.data_ok; obs_aok = bus3.dresp.addr_ok; obs_data = bus3.dresp.data;
               obs_err = err3; obs_rd = rd3; obs_wr = wr3; end
      default: ;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[15];

  int checks = 0;
  int errors = 0;
  int exp_rd[4] = '{0, 0, 0, 0};
  int exp_wr[4] = '{0, 0, 0, 0};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instance s is built with LATENCY = s.
  function automatic int lat_of(int s);
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      if (obs_dok) begin
        if (sbq.size() == 0) begin
          chk("unexpected_data_ok", obs_dok, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_data", obs_data, e.data);
          chk("resp_err", obs_err, e.err);
          chk("resp_addr_ok", obs_aok, 1'b1);
        end
      end else begin
        chk("err_without_data_ok", obs_err, 1'b0);
      end
    end
  end

  task automatic drive(int s, logic [63:0] a, logic [7:0] st, logic [63:0] d);
    sel = s; r_valid = 1'b1; r_addr = a; r_strobe = st; r_data = d;
    r_size = 3'($urandom_range(7, 0));
  endtask

  task automatic expect_resp(int s, logic [63:0] ed, logic e);
    exp_t x;
    x.cyc = cyc + lat_of(s); x.data = ed; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic wait_dok();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      seen = obs_dok;
    end
    if (!seen) chk("response_timeout", obs_dok, 1'b1);
  endtask

  task automatic access(int s, logic [63:0] a, logic [7:0] st, logic [63:0] d, logic [63:0] ed, logic e);
    drive(s, a, st, d);
    expect_resp(s, ed, e);
    if (!e) begin
      if (st != '0) exp_wr[s]++;
      else          exp_rd[s]++;
    end
    wait_dok();
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish by 50000");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{64'h0000_0000_8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0},
      '{64'h0000_0000_8000_0010, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0},
      '{64'h0000_0000_8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 1'b0},
      '{64'h0000_0000_8000_0010, 8'h00, 64'h0, 64'h1122_3344_BBBB_BBBB, 1'b0},
      '{64'h0000_0000_7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1},
      '{64'h0000_0000_8000_0000, 8'hFF, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0},
      '{64'h0000_0000_8000_0200, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1},
      '{64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0},
      '{64'h0000_0000_8000_01F8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0},
      '{64'h0000_0000_8000_01F9, 8'h81, 64'hAA00_0000_0000_00BB, 64'h0, 1'b0},
      '{64'h0000_0000_8000_01FF, 8'h00, 64'h0, 64'hAA23_4567_89AB_CDBB, 1'b0},
      '{64'h0000_0000_8000_000C, 8'h00, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0},
      '{64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1},
      '{64'h0000_0000_0000_0000, 8'h01, 64'h55, 64'h0, 1'b1},
      '{64'h0000_0000_8000_0010, 8'h00, 64'h0, 64'h1122_3344_BBBB_BBBB, 1'b0}
    };

    // Reset held with a request pending; nothing may be accepted until release.
    drive(2, BASE + 64'd8, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F);
    repeat (3) begin
      @(negedge clk);
      chk("rst_data_ok", obs_dok, 1'b0);
      chk("rst_data", obs_data, 64'h0);
      chk("rst_err", obs_err, 1'b0);
      chk("rst_rd_cnt", obs_rd, 32'h0);
      chk("rst_wr_cnt", obs_wr, 32'h0);
    end
    reset = 1'b1;
    expect_resp(2, 64'h0, 1'b0);
    exp_wr[2]++;
    wait_dok();
    @(negedge clk);
    r_valid = 1'b0;

    for (int i = 0; i < 15; i++)
      access(2, vecs[i].addr, vecs[i].strobe, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err);
    @(negedge clk);
    chk("lat2_rd_cnt", rd2, 32'(exp_rd[2]));
    chk("lat2_wr_cnt", wr2, 32'(exp_wr[2]));

    // Abort: valid drops while the LATENCY=3 write sits in WAIT.
    access(3, BASE + 64'h20, 8'hFF, 64'h1111_1111_1111_1111, 64'h0, 1'b0);
    drive(3, BASE + 64'h20, 8'hFF, 64'h2222_2222_2222_2222);
    @(negedge clk);
    r_valid = 1'b0;
    @(negedge clk);
    access(3, BASE + 64'h20, 8'h00, 64'h0, 64'h1111_1111_1111_1111, 1'b0);
    chk("abort_wr_cnt", wr3, 32'(exp_wr[3]));
    chk("abort_rd_cnt", rd3, 32'(exp_rd[3]));

    // LATENCY=1 back-to-back: each access returns at the negedge after data_ok, so valid never drops between them.
    for (int i = 0; i < 4; i++)
      access(1, BASE + 64'(8 * i), 8'hFF, 64'h0101_0101_0101_0101 * 64'(i + 1), 64'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      access(1, BASE + 64'(8 * i), 8'h00, 64'h0, 64'h0101_0101_0101_0101 * 64'(i + 1), 1'b0);
    chk("b2b_rd_cnt", rd1, 32'd4);
    chk("b2b_wr_cnt", wr1, 32'd4);

    // Reset during a read response clears outputs and counters at once.
    drive(1, BASE + 64'h10, 8'h00, 64'h0);
    expect_resp(1, 64'h0303_0303_0303_0303, 1'b0);
    wait_dok();
    #1 reset = 1'b0;
    #1;
    chk("midrst_data_ok", obs_dok, 1'b0);
    chk("midrst_data", obs_data, 64'h0);
    chk("midrst_rd_cnt", obs_rd, 32'h0);
    chk("midrst_wr_cnt", obs_wr, 32'h0);
    r_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Reset during a write response must keep the write out of memory.
    drive(1, BASE, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
    expect_resp(1, 64'h0, 1'b0);
    wait_dok();
    #1 reset = 1'b0;
    r_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1, BASE, 8'h00, 64'h0, 64'h0101_0101_0101_0101, 1'b0);
    chk("post_rst_rd_cnt", rd1, 32'd1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
